// File: rtl/muldiv_if.sv
// Request/response channel between the execute stage and the muldiv unit.
// Signal names carry the unit-side direction suffix.
interface muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic [2:0]      req_op_i;
    logic [XLEN-1:0] req_src1_i;
    logic [XLEN-1:0] req_src2_i;
    logic            kill_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [XLEN-1:0] rsp_rslt_o;
    logic            busy_o;

    modport master (
        output req_valid_i, req_op_i, req_src1_i, req_src2_i, kill_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rslt_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_src1_i, req_src2_i, kill_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rslt_o, busy_o
    );
endinterface

// File: rtl/muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: STEP result bits per cycle,
// magnitude datapath with sign correction on the final iteration.
module muldiv #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = 1
) (
    input logic     clk_i,
    input logic     rst_ni,
    muldiv_if.slave bus
);
    localparam int unsigned N  = XLEN / STEP;
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    if (!((XLEN == 32 || XLEN == 64) && (STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8)
          && (XLEN % STEP == 0))) begin : g_bad_param
        $fatal(1, "FATAL: muldiv needs XLEN in {32,64}, STEP in {1,2,4,8}, XLEN%%STEP==0");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   rslt_q, rslt_d;

    logic              is_div, s1_neg, s2_neg, div0, ovf;
    logic [XLEN-1:0]   abs1, abs2;

    always_comb begin : decode
        is_div = bus.req_op_i[2];
        s1_neg = (bus.req_op_i == 3'd1 || bus.req_op_i == 3'd2 || bus.req_op_i == 3'd4 ||
                  bus.req_op_i == 3'd6) && bus.req_src1_i[XLEN-1];
        s2_neg = (bus.req_op_i == 3'd1 || bus.req_op_i == 3'd4 || bus.req_op_i == 3'd6) &&
                 bus.req_src2_i[XLEN-1];
        abs1   = s1_neg ? -bus.req_src1_i : bus.req_src1_i;
        abs2   = s2_neg ? -bus.req_src2_i : bus.req_src2_i;
        div0   = is_div && (bus.req_src2_i == '0);
        ovf    = (bus.req_op_i == 3'd4 || bus.req_op_i == 3'd6) &&
                 (bus.req_src1_i == MIN_NEG) && (bus.req_src2_i == '1);
    end

    logic [STEP-1:0]      digit;
    logic [XLEN+STEP-1:0] mul_sum;
    logic [XLEN:0]        div_t;
    logic [XLEN-1:0]      div_r, div_q, quo_c, rem_c, final_rslt;
    logic [2*XLEN-1:0]    mul_acc, step_acc, prod_c;

    // acc holds {partial, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin : iterate
        digit   = acc_q[STEP-1:0];
        mul_sum = {{STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]} +
                  ({{STEP{1'b0}}, opnd_q} * {{XLEN{1'b0}}, digit});
        mul_acc = {mul_sum, acc_q[XLEN-1:STEP]};

        div_r = acc_q[2*XLEN-1:XLEN];
        div_q = acc_q[XLEN-1:0];
        div_t = '0;
        for (int unsigned i = 0; i < STEP; i++) begin
            div_t = {div_r, div_q[XLEN-1]};
            div_q = {div_q[XLEN-2:0], 1'b0};
            if (div_t >= {1'b0, opnd_q}) begin
                div_t    = div_t - {1'b0, opnd_q};
                div_q[0] = 1'b1;
            end
            div_r = div_t[XLEN-1:0];
        end

        step_acc = op_q[2] ? {div_r, div_q} : mul_acc;
        prod_c   = neg_q ? -step_acc : step_acc;
        quo_c    = neg_q ? -div_q : div_q;
        rem_c    = neg_q ? -div_r : div_r;
        case (op_q)
            3'd0:                final_rslt = prod_c[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    final_rslt = prod_c[2*XLEN-1:XLEN];
            3'd4, 3'd5:          final_rslt = quo_c;
            default:             final_rslt = rem_c;
        endcase
    end

    always_comb begin : fsm
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        rslt_d  = rslt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i && !bus.kill_i) begin
                    op_d    = bus.req_op_i;
                    // remainders follow the dividend sign, everything else the sign product
                    neg_d   = (is_div && bus.req_op_i[1]) ? s1_neg : (s1_neg ^ s2_neg);
                    opnd_d  = is_div ? abs2 : abs1;
                    acc_d   = {{XLEN{1'b0}}, (is_div ? abs1 : abs2)};
                    cnt_d   = CW'(N);
                    state_d = CALC;
                    if (div0) begin
                        rslt_d  = bus.req_op_i[1] ? bus.req_src1_i : '1;
                        state_d = DONE;
                    end else if (ovf) begin
                        rslt_d  = bus.req_op_i[1] ? '0 : bus.req_src1_i;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                if (bus.kill_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        rslt_d  = final_rslt;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.kill_i || bus.rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            rslt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            rslt_q  <= rslt_d;
        end
    end

    assign bus.req_ready_o = (state_q == IDLE) && !bus.kill_i;
    assign bus.rsp_valid_o = (state_q == DONE) && !bus.kill_i;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.rsp_rslt_o  = rslt_q;
endmodule

// File: doc/muldiv.md
# muldiv

Iterative RV32M/RV64M multiply/divide unit for the next-generation `rei` core. It sits beside the ALU in the execute stage and accepts one operation at a time over a valid/ready request channel. It returns the result over a valid/ready response channel after a parametrised number of cycles, so the core stalls on M-extension instructions instead of needing a single-cycle multiplier. A `kill_i` input lets the core abandon an in-flight operation on a trap or redirect.

## Interface
- `XLEN`, default 32: operand and result width; must be 32 or 64.
- `STEP`, default 1: result bits retired per iteration; must be 1, 2, 4 or 8, and `XLEN % STEP == 0`. Any other value raises an elaboration-time `FATAL`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock, reset is asynchronous and active-low.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  unit can accept a request.
- `req_op_i`  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `req_src1_i`  in  XLEN  rs1 operand (multiplicand or dividend).
- `req_src2_i`  in  XLEN  rs2 operand (multiplier or divisor).
- `kill_i`  in  1  abort the current operation; no response is produced.
- `rsp_valid_o`  out  1  result available.
- `rsp_ready_i`  in  1  core consumes the result.
- `rsp_rslt_o`  out  XLEN  result; held stable while `rsp_valid_o && !rsp_ready_i`.
- `busy_o`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE:**
  - `req_ready_o = !kill_i`.
  - On accept, latch the op, the operand signs and the absolute values. Signed ops use two's-complement magnitude; MULHSU treats only src1 as signed.
  - Next state is CALC with `cnt = XLEN/STEP`, or DONE directly for the special divide cases.
- **CALC:**
  - Multiply: radix-2^STEP shift-add over a 2·XLEN-bit accumulator.
  - Divide: STEP restoring-division steps per cycle.
  - `cnt` decrements each cycle. When `cnt == 1`, sign correction is applied and the registered result is written; next state is DONE.
- **DONE:** `rsp_valid_o = 1`. On `rsp_ready_i`, next state is IDLE.
- **Result selection:**
  - MUL returns the low XLEN bits of the product.
  - MULH, MULHSU and MULHU return the high XLEN bits.
  - The quotient is negated if the operand signs differ (signed ops only).
  - The remainder takes the dividend's sign.
- **Special cases** (decided at accept, skip CALC):
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return src1.
  - Signed overflow (src1 = -2^(XLEN-1), src2 = -1): DIV returns src1; REM returns 0.
- **Kill:** `kill_i` in CALC or DONE forces IDLE at the next edge. `rsp_valid_o` drops, no response is emitted, and the partial state is discarded. `kill_i` takes priority over `rsp_ready_i` and over `req_valid_i`.
- **Reset** (async, on `rst_ni` low):
  - State goes to IDLE immediately; counter, accumulators and result are cleared.
  - Output values during and after reset: `req_ready_o = 1` (while `kill_i` is 0), `rsp_valid_o = 0`, `rsp_rslt_o = 0`, `busy_o = 0`.
  - An operation in flight during reset is lost.

## Timing
- Accept at edge 0 (`req_valid_i && req_ready_o`). CALC occupies cycles 1..N with N = XLEN/STEP. `rsp_valid_o` rises in cycle N+1.
  - XLEN=32: STEP=1 gives response in cycle 33; STEP=4 gives cycle 9.
- Special divide cases: `rsp_valid_o` in cycle 1.
- Response handshake at edge k returns to IDLE. `req_ready_o` is high in cycle k+1, giving a 1-cycle bubble between back-to-back operations.
- No combinational path from `req_*` to `rsp_*`. `req_ready_o` depends combinationally only on state and `kill_i`.
- Operands are sampled only at accept. Changes on `req_src*_i` afterwards have no effect.

## Test plan
- **MUL/MULHU** (XLEN=32, STEP=1):
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB, `rsp_valid_o` first high in cycle 33.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- **MULH/MULHSU:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000.
- **DIV/REM:**
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU → 2.
- **Special cases:** each with response in cycle 1.
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- **Handshake:**
  - Hold `rsp_ready_i` low 10 cycles: `rsp_rslt_o` stable, `req_ready_o` low, `busy_o` high.
  - Assert `kill_i` in cycle 10 of a CALC: IDLE next cycle, no response. A new MUL 3 × 4 issued immediately after returns 12.
- **Reset and parameters:**
  - Drop `rst_ni` mid-CALC: all outputs take reset values without a clock edge.
  - STEP=4 and XLEN=64 builds: random op/operand sweep against a reference model. Latency is N+1 with N=8 and N=16 respectively.
